// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of osc_in over a gate window of clk cycles.
// Optional back-to-back measurement mode is enabled by defining RING_OSC_FREQ_METER_CONT_EN (adds input cont).
module ring_osc_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 20,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              osc_in,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_len,
`ifdef RING_OSC_FREQ_METER_CONT_EN
  input  logic              cont,
`endif
  output logic              busy,
  output logic              valid,
  output logic [CNT_W-1:0]  count,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   osc_edge;
  logic [GATE_W-1:0]      gate_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic                   ovf_flag;

  // osc_in is asynchronous to clk; only the last synchronizer stage is ever looked at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge values, so the chain shifts one stage per clock.
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign osc_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      count    <= '0;
      ovf      <= 1'b0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
            valid <= 1'b0;
          end
        end

        ARM: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
          end else begin
            gate_cnt <= (gate_len == '0) ? GATE_W'(1) : gate_len;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
            valid    <= 1'b0;
            state    <= MEASURE;
          end
        end

        MEASURE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
          end else begin
            // Saturate rather than wrap, so an overrange reading is never mistaken for a small one.
            if (osc_edge) begin
              if (edge_cnt == '1) ovf_flag <= 1'b1;
              else                edge_cnt <= edge_cnt + CNT_W'(1);
            end
            gate_cnt <= gate_cnt - GATE_W'(1);
            if (gate_cnt == GATE_W'(1)) state <= DONE;
          end
        end

        DONE: begin
          count <= edge_cnt;
          ovf   <= ovf_flag;
          valid <= 1'b1;
`ifdef RING_OSC_FREQ_METER_CONT_EN
          if (cont) begin
            state <= ARM;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
